// File: rtl/ipu_pkg.sv
// Shared definitions for the image-processing pipeline blocks.
//   COORD_W_DEF / CNT_W_DEF : default coordinate and pixel-count widths
//   trk_state_t             : blob tracker FSM states
//   lane_lsb()              : LSB position of a lane in a channel-packed bus
package ipu_pkg;

    localparam int COORD_W_DEF = 11;
    localparam int CNT_W_DEF   = 22;

    typedef enum logic [1:0] {
        ACCUM,
        CALC,
        UPDATE
    } trk_state_t;

    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/multi_blob_tracker_if.sv
// Start/done handshake bus between the blob tracker and its shared divider.
//   start    : one-cycle request, operands sampled with it
//   dividend : DVD_W-bit numerator
//   divisor  : DVS_W-bit denominator
//   done     : one-cycle pulse, quotient valid from this cycle until next start
//   quotient : DVD_W-bit floor(dividend/divisor), 0 when divisor is 0
interface multi_blob_tracker_if
    import ipu_pkg::*;
#(
    parameter int DVD_W = COORD_W_DEF + CNT_W_DEF,
    parameter int DVS_W = CNT_W_DEF
);
    logic             start;
    logic [DVD_W-1:0] dividend;
    logic [DVS_W-1:0] divisor;
    logic             done;
    logic [DVD_W-1:0] quotient;

    modport master (output start, dividend, divisor, input done, quotient);
    modport slave  (input start, dividend, divisor, output done, quotient);
endinterface

// File: rtl/seq_divider.sv
// Restoring divider retiring one quotient bit per cycle.
//   iCLK, iRST : clock, asynchronous active-low reset
//   bus        : slave side of the start/done handshake
// The start cycle already performs the first iteration, so done pulses
// exactly DVD_W cycles after start. A new start restarts immediately.
module seq_divider
    import ipu_pkg::*;
#(
    parameter int DVD_W = COORD_W_DEF + CNT_W_DEF,
    parameter int DVS_W = CNT_W_DEF
) (
    input  logic iCLK,
    input  logic iRST,
    multi_blob_tracker_if.slave bus
);

    localparam int LEFT_W = $clog2(DVD_W + 1);

    logic [DVS_W-1:0]  dvs_q, dvs_use, rem_q, rem_in, rem_next;
    logic [DVD_W-1:0]  dq_q, dq_in;
    logic [LEFT_W-1:0] left_q;
    logic              run_q, done_q;
    logic [DVS_W:0]    trial;
    logic              take;

    always_comb begin
        if (bus.start) begin
            dvs_use = bus.divisor;
            rem_in  = '0;
            dq_in   = bus.dividend;
        end else begin
            dvs_use = dvs_q;
            rem_in  = rem_q;
            dq_in   = dq_q;
        end
        trial = {rem_in, dq_in[DVD_W-1]};
        // A zero divisor never subtracts, so the quotient shifts in zeros.
        take  = (dvs_use != '0) && (trial >= {1'b0, dvs_use});
        // When taken the difference is below the divisor, so DVS_W bits suffice.
        rem_next = take ? (trial[DVS_W-1:0] - dvs_use) : trial[DVS_W-1:0];
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            dvs_q  <= '0;
            rem_q  <= '0;
            dq_q   <= '0;
            left_q <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.start || run_q) begin
                rem_q <= rem_next;
                dq_q  <= {dq_in[DVD_W-2:0], take};
            end
            if (bus.start) begin
                dvs_q  <= bus.divisor;
                left_q <= LEFT_W'(DVD_W - 1);
                run_q  <= 1'b1;
            end else if (run_q) begin
                left_q <= left_q - 1'b1;
                if (left_q == LEFT_W'(1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.done     = done_q;
    assign bus.quotient = dq_q;

endmodule

// File: rtl/multi_blob_tracker.sv
// Per-channel colour blob centroid tracker.
//   iCLK, iRST            : clock, asynchronous active-low reset
//   iDVAL, iHit           : pixel valid, per-channel colour hit
//   iX_Cont, iY_Cont      : pixel coordinates
//   iEOF                  : end-of-frame pulse (a coincident pixel belongs to the ending frame)
//   oX, oY                : channel-packed smoothed centroids, channel 0 in the LSBs
//   oFound                : blob seen with at least MIN_COUNT pixels in the last processed frame
//   oDVAL                 : one-cycle pulse when oX/oY/oFound update
//   oBusy                 : centroid calculation in progress
//   oOverrun              : one-cycle pulse when a frame ended during calculation and was dropped
module multi_blob_tracker
    import ipu_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int COORD_W      = COORD_W_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int MIN_COUNT    = 16,
    parameter int SMOOTH_SHIFT = 2
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    input  logic                      iDVAL,
    input  logic [NUM_CH-1:0]         iHit,
    input  logic [COORD_W-1:0]        iX_Cont,
    input  logic [COORD_W-1:0]        iY_Cont,
    input  logic                      iEOF,
    output logic [NUM_CH*COORD_W-1:0] oX,
    output logic [NUM_CH*COORD_W-1:0] oY,
    output logic [NUM_CH-1:0]         oFound,
    output logic                      oDVAL,
    output logic                      oBusy,
    output logic                      oOverrun
);

    localparam int SUM_W  = COORD_W + CNT_W;
    localparam int NDIV   = 2 * NUM_CH;
    localparam int IDX_W  = $clog2(NDIV);
    localparam int SLOT_W = $clog2(SUM_W);
    localparam int PAD_W  = SUM_W + 1 - COORD_W;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SUM_W - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NDIV - 1);
    localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(MIN_COUNT);

    trk_state_t state_q, state_d;

    logic [CNT_W-1:0]   cnt_q [NUM_CH], cnt_n [NUM_CH], snap_cnt [NUM_CH];
    logic [SUM_W-1:0]   sx_q [NUM_CH], sx_n [NUM_CH], snap_sx [NUM_CH];
    logic [SUM_W-1:0]   sy_q [NUM_CH], sy_n [NUM_CH], snap_sy [NUM_CH];
    logic [COORD_W-1:0] raw_q [NDIV-1], raw_all [NDIV];
    logic [SLOT_W-1:0]  slot_q;
    logic [IDX_W-1:0]   idx_q;
    logic [NUM_CH*COORD_W-1:0] x_q, y_q;
    logic [NUM_CH-1:0]  found_q;
    logic               dval_q, ovr_q;
    logic               div_start;
    logic [SUM_W-1:0]   div_dvd, quo;
    logic [CNT_W-1:0]   div_dvs;
    logic               unused_quo_hi;

    multi_blob_tracker_if #(.DVD_W(SUM_W), .DVS_W(CNT_W)) div_bus ();

    seq_divider #(.DVD_W(SUM_W), .DVS_W(CNT_W)) u_div (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (div_bus)
    );

    assign div_bus.start    = div_start;
    assign div_bus.dividend = div_dvd;
    assign div_bus.divisor  = div_dvs;
    assign quo              = div_bus.quotient;
    assign unused_quo_hi    = ^quo[SUM_W-1:COORD_W];

    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a, input logic [COORD_W-1:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + {{PAD_W{1'b0}}, b};
        return s[SUM_W] ? '1 : s[SUM_W-1:0];
    endfunction

    function automatic logic [COORD_W-1:0] blend(input logic [COORD_W-1:0] old_v,
                                                 input logic [COORD_W-1:0] raw_v,
                                                 input logic load);
        logic signed [COORD_W:0] diff;
        diff = $signed({1'b0, raw_v}) - $signed({1'b0, old_v});
        if (load) return raw_v;
        return old_v + COORD_W'(diff >>> SMOOTH_SHIFT);
    endfunction

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) state_q <= ACCUM;
        else       state_q <= state_d;
    end

    // Divisions run back to back, one per SUM_W-cycle slot: idx = 2*ch + axis.
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        unique case (state_q)
            ACCUM:  if (iEOF) state_d = CALC;
            CALC: begin
                div_start = (slot_q == '0);
                if (slot_q == SLOT_LAST && idx_q == IDX_LAST) state_d = UPDATE;
            end
            UPDATE: state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        div_dvd = '0;
        div_dvs = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (32'(idx_q) == 2 * c) begin
                div_dvd = snap_sx[c];
                div_dvs = snap_cnt[c];
            end
            if (32'(idx_q) == 2 * c + 1) begin
                div_dvd = snap_sy[c];
                div_dvs = snap_cnt[c];
            end
        end
    end

    // The last quotient is still in the divider during UPDATE.
    always_comb begin
        for (int unsigned k = 0; k < NDIV - 1; k++) raw_all[k] = raw_q[k];
        raw_all[NDIV-1] = quo[COORD_W-1:0];
    end

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            cnt_n[c] = cnt_q[c];
            sx_n[c]  = sx_q[c];
            sy_n[c]  = sy_q[c];
            if (iDVAL && iHit[c]) begin
                cnt_n[c] = (&cnt_q[c]) ? cnt_q[c] : cnt_q[c] + 1'b1;
                sx_n[c]  = sat_add(sx_q[c], iX_Cont);
                sy_n[c]  = sat_add(sy_q[c], iY_Cont);
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                cnt_q[c]    <= '0;
                sx_q[c]     <= '0;
                sy_q[c]     <= '0;
                snap_cnt[c] <= '0;
                snap_sx[c]  <= '0;
                snap_sy[c]  <= '0;
            end
            for (int unsigned k = 0; k < NDIV - 1; k++) raw_q[k] <= '0;
            slot_q  <= '0;
            idx_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            found_q <= '0;
            dval_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            dval_q <= (state_q == UPDATE);
            ovr_q  <= iEOF && (state_q != ACCUM);

            for (int unsigned c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= iEOF ? '0 : cnt_n[c];
                sx_q[c]  <= iEOF ? '0 : sx_n[c];
                sy_q[c]  <= iEOF ? '0 : sy_n[c];
                if (iEOF && state_q == ACCUM) begin
                    snap_cnt[c] <= cnt_n[c];
                    snap_sx[c]  <= sx_n[c];
                    snap_sy[c]  <= sy_n[c];
                end
            end

            if (state_q != CALC) begin
                slot_q <= '0;
                idx_q  <= '0;
            end else if (slot_q == SLOT_LAST) begin
                slot_q <= '0;
                idx_q  <= idx_q + 1'b1;
            end else begin
                slot_q <= slot_q + 1'b1;
            end

            // done for division k-1 lands in the first slot cycle of division k.
            if (state_q == CALC && div_bus.done) begin
                for (int unsigned k = 0; k < NDIV - 1; k++)
                    if (32'(idx_q) == k + 1) raw_q[k] <= quo[COORD_W-1:0];
            end

            if (state_q == UPDATE) begin
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    if (snap_cnt[c] < MIN_C) begin
                        found_q[c] <= 1'b0;
                    end else begin
                        found_q[c] <= 1'b1;
                        x_q[lane_lsb(c, COORD_W) +: COORD_W] <=
                            blend(x_q[lane_lsb(c, COORD_W) +: COORD_W], raw_all[2*c],
                                  !found_q[c] || SMOOTH_SHIFT == 0);
                        y_q[lane_lsb(c, COORD_W) +: COORD_W] <=
                            blend(y_q[lane_lsb(c, COORD_W) +: COORD_W], raw_all[2*c+1],
                                  !found_q[c] || SMOOTH_SHIFT == 0);
                    end
                end
            end
        end
    end

    assign oX       = x_q;
    assign oY       = y_q;
    assign oFound   = found_q;
    assign oDVAL    = dval_q;
    assign oBusy    = (state_q != ACCUM);
    assign oOverrun = ovr_q;

endmodule

// File: tb/tb_multi_blob_tracker.sv
// Directed bench for multi_blob_tracker: two instances (no smoothing and
// SMOOTH_SHIFT=2) share one pixel stream; a standalone divider is driven
// from a vector table through the handshake interface.
module tb_multi_blob_tracker;
    import ipu_pkg::*;

    localparam int NUM_CH  = 2;
    localparam int COORD_W = 11;
    localparam int CNT_W   = 22;
    localparam int SUM_W   = 33;
    localparam int LAT     = 2 * NUM_CH * SUM_W + 2;

    logic clk = 1'b0, rst_n = 1'b0, dval = 1'b0, eof = 1'b0;
    logic [NUM_CH-1:0] hit = '0;
    logic [COORD_W-1:0] xc = '0, yc = '0;
    logic [NUM_CH*COORD_W-1:0] ox0, oy0, ox1, oy1;
    logic [NUM_CH-1:0] f0, f1;
    logic dv0, dv1, bz0, bz1, ov0, ov1;

    int checks = 0, errors = 0;
    int ovr_cnt = 0, dval_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ov0) ovr_cnt++;
        if (dv0) dval_cnt++;
    end

    multi_blob_tracker #(.NUM_CH(NUM_CH), .COORD_W(COORD_W), .CNT_W(CNT_W),
                         .MIN_COUNT(16), .SMOOTH_SHIFT(0)) u_dut0 (
        .iCLK(clk), .iRST(rst_n), .iDVAL(dval), .iHit(hit), .iX_Cont(xc), .iY_Cont(yc),
        .iEOF(eof), .oX(ox0), .oY(oy0), .oFound(f0), .oDVAL(dv0), .oBusy(bz0), .oOverrun(ov0));

    multi_blob_tracker #(.NUM_CH(NUM_CH), .COORD_W(COORD_W), .CNT_W(CNT_W),
                         .MIN_COUNT(16), .SMOOTH_SHIFT(2)) u_dut1 (
        .iCLK(clk), .iRST(rst_n), .iDVAL(dval), .iHit(hit), .iX_Cont(xc), .iY_Cont(yc),
        .iEOF(eof), .oX(ox1), .oY(oy1), .oFound(f1), .oDVAL(dv1), .oBusy(bz1), .oOverrun(ov1));

    multi_blob_tracker_if #(.DVD_W(SUM_W), .DVS_W(CNT_W)) dbus ();
    seq_divider #(.DVD_W(SUM_W), .DVS_W(CNT_W)) u_div (.iCLK(clk), .iRST(rst_n), .bus(dbus));

    typedef struct {
        logic [SUM_W-1:0] dvd;
        logic [CNT_W-1:0] dvs;
        logic [SUM_W-1:0] q;
    } div_vec_t;
    div_vec_t dvec [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [21:0] ox, input logic [21:0] oy,
                             input logic [1:0] f, input int ex0, input int ey0,
                             input int ex1, input int ey1, input logic [1:0] ef);
        check({tag, ".found"}, f, ef);
        check({tag, ".x0"}, ox[10:0], ex0);
        check({tag, ".y0"}, oy[10:0], ey0);
        check({tag, ".x1"}, ox[21:11], ex1);
        check({tag, ".y1"}, oy[21:11], ey1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".dut0"}, {ox0, oy0, f0, dv0, bz0, ov0}, 0);
        check({tag, ".dut1"}, {ox1, oy1, f1, dv1, bz1, ov1}, 0);
    endtask

    // Called just after a negedge; drives one cycle and returns at the next negedge.
    task automatic pix(input logic [1:0] h, input int x, input int y, input logic e);
        dval = (h != 2'b00);
        hit  = h;
        xc   = COORD_W'(x);
        yc   = COORD_W'(y);
        eof  = e;
        @(negedge clk);
        dval = 1'b0;
        hit  = '0;
        eof  = 1'b0;
    endtask

    task automatic hits(input logic [1:0] h, input int x, input int y, input int n);
        for (int i = 0; i < n; i++) pix(h, x, y, 1'b0);
    endtask

    task automatic wait_dval(input int n0, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = n0;
        repeat (400) begin
            @(negedge clk);
            lat++;
            if (dv0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("dval_timeout", 0, 1);
    endtask

    task automatic frame_end(input string tag);
        int lat;
        pix(2'b00, 0, 0, 1'b1);
        wait_dval(1, lat);
        check({tag, ".latency"}, lat, LAT);
        check({tag, ".dval1"}, dv1, 1);
    endtask

    initial begin
        int lat, base;

        dvec[0] = '{33'd1624, 22'd16, 33'd101};
        dvec[1] = '{33'd824, 22'd16, 33'd51};
        dvec[2] = '{33'd100, 22'd3, 33'd33};
        dvec[3] = '{33'd7, 22'd0, 33'd0};
        dvec[4] = '{33'h1_FFFF_FFFF, 22'd1, 33'h1_FFFF_FFFF};
        dvec[5] = '{33'h1_FFFF_FFFF, 22'h3F_FFFF, 33'd2048};
        dvec[6] = '{33'd5, 22'd7, 33'd0};

        dbus.start    = 1'b0;
        dbus.dividend = '0;
        dbus.divisor  = '0;

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        foreach (dvec[i]) begin
            bit seen;
            int n;
            dbus.start    = 1'b1;
            dbus.dividend = dvec[i].dvd;
            dbus.divisor  = dvec[i].dvs;
            @(negedge clk);
            dbus.start = 1'b0;
            n = 1;
            seen = 1'b0;
            repeat (60) begin
                if (dbus.done) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clk);
                n++;
            end
            check($sformatf("div%0d.latency", i), seen ? n : -1, SUM_W);
            check($sformatf("div%0d.quot", i), dbus.quotient, dvec[i].q);
        end

        // 4x4 square, last pixel coincides with end of frame.
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++)
                pix(2'b01, 100 + i, 50 + j, (i == 3 && j == 3));
        check("A.busy", {bz0, bz1}, 2'b11);
        wait_dval(1, lat);
        check("A.latency", lat, LAT);
        check("A.idle_after", {bz0, bz1}, 2'b00);
        check_out("A.d0", ox0, oy0, f0, 101, 51, 0, 0, 2'b01);
        check_out("A.d1", ox1, oy1, f1, 101, 51, 0, 0, 2'b01);
        @(negedge clk);
        check("A.dval_pulse", {dv0, dv1}, 2'b00);

        hits(2'b10, 10, 20, 15);
        frame_end("B");
        check_out("B.d0", ox0, oy0, f0, 101, 51, 0, 0, 2'b00);
        check_out("B.d1", ox1, oy1, f1, 101, 51, 0, 0, 2'b00);

        hits(2'b01, 100, 100, 16);
        hits(2'b10, 200, 300, 16);
        frame_end("C");
        check_out("C.d0", ox0, oy0, f0, 100, 100, 200, 300, 2'b11);
        check_out("C.d1", ox1, oy1, f1, 100, 100, 200, 300, 2'b11);

        hits(2'b01, 200, 40, 16);
        frame_end("D");
        check_out("D.d0", ox0, oy0, f0, 200, 40, 200, 300, 2'b01);
        check_out("D.d1", ox1, oy1, f1, 125, 85, 200, 300, 2'b01);

        // Second end of frame arrives 50 cycles into the calculation.
        hits(2'b01, 50, 60, 16);
        pix(2'b00, 0, 0, 1'b1);
        base = ovr_cnt;
        hits(2'b01, 500, 500, 16);
        repeat (33) @(negedge clk);
        pix(2'b00, 0, 0, 1'b1);
        wait_dval(51, lat);
        check("E.latency", lat, LAT);
        check("E.overruns", ovr_cnt - base, 1);
        check_out("E.d0", ox0, oy0, f0, 50, 60, 200, 300, 2'b01);
        check_out("E.d1", ox1, oy1, f1, 106, 78, 200, 300, 2'b01);

        hits(2'b10, 7, 9, 16);
        frame_end("F");
        check_out("F.d0", ox0, oy0, f0, 50, 60, 7, 9, 2'b10);
        check_out("F.d1", ox1, oy1, f1, 106, 78, 7, 9, 2'b10);

        // Reset 60 cycles into the calculation.
        hits(2'b01, 300, 300, 16);
        pix(2'b00, 0, 0, 1'b1);
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("G.reset");
        base  = dval_cnt;
        rst_n = 1'b1;
        hits(2'b01, 30, 40, 16);
        frame_end("H");
        check_out("H.d0", ox0, oy0, f0, 30, 40, 0, 0, 2'b01);
        check_out("H.d1", ox1, oy1, f1, 30, 40, 0, 0, 2'b01);
        @(negedge clk);
        check("H.dval_count", dval_cnt - base, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
